// File: rtl/capture_sequencer_pkg.sv
// Shared definitions for the logic-analyzer capture path: state encodings and
// width defaults, also consumed by the status register block.
package capture_sequencer_pkg;

    localparam int LIMIT_W_DEF = 32;
    localparam int PRE_W_DEF   = 16;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_PRE       = 3'd1;
    localparam logic [2:0] ST_WAIT_TRIG = 3'd2;
    localparam logic [2:0] ST_RUN       = 3'd3;
    localparam logic [2:0] ST_DONE      = 3'd4;

    function automatic logic st_is_busy(input logic [2:0] st);
        return (st == ST_PRE) || (st == ST_WAIT_TRIG) || (st == ST_RUN);
    endfunction

endpackage

// File: rtl/la_down_counter.sv
// Loadable down counter with a zero flag; saturates at zero.
module la_down_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] count,
    output logic         zero
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (en && (count_q != '0)) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign zero  = (count_q == '0);

endmodule

// File: rtl/capture_sequencer.sv
// Capture controller: arm -> optional pre-trigger window -> wait for trigger ->
// run until step_limiter stop (or abort). All outputs come from registers.
module capture_sequencer
    import capture_sequencer_pkg::*;
#(
    parameter int LIMIT_W = LIMIT_W_DEF,
    parameter int PRE_W   = PRE_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               arm,
    input  logic               abort,
    input  logic               trigger,
    input  logic [LIMIT_W-1:0] cfg_limit,
    input  logic               cfg_do_limit,
    input  logic [PRE_W-1:0]   cfg_pre,
    input  logic               stop,
    output logic               run,
    output logic [LIMIT_W-1:0] limit,
    output logic               do_limit,
    output logic               sample_en,
    output logic               busy,
    output logic               done,
    output logic               trig_early,
    output logic [2:0]         state
);

    logic [2:0]         state_q, state_d;
    logic [LIMIT_W-1:0] limit_q, limit_d;
    logic               do_limit_q, do_limit_d;
    logic               trig_early_q, trig_early_d;

    logic               arm_ok;
    logic               pre_load;
    logic               pre_en;
    logic [PRE_W-1:0]   pre_cnt;
    logic               pre_zero;
    logic               pre_last;

    assign arm_ok   = arm && !abort && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign pre_load = arm_ok;
    assign pre_en   = (state_q == ST_PRE);
    // Leave PRE on the cycle the counter is about to reach zero, giving cfg_pre PRE cycles.
    assign pre_last = (pre_cnt == PRE_W'(1)) || pre_zero;

    la_down_counter #(.W(PRE_W)) u_pre_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (pre_load),
        .en       (pre_en),
        .load_val (cfg_pre),
        .count    (pre_cnt),
        .zero     (pre_zero)
    );

    always_comb begin
        state_d      = state_q;
        limit_d      = limit_q;
        do_limit_d   = do_limit_q;
        trig_early_d = trig_early_q;

        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (arm) begin
                        limit_d      = cfg_limit;
                        do_limit_d   = cfg_do_limit;
                        trig_early_d = 1'b0;
                        state_d      = (cfg_pre != '0) ? ST_PRE : ST_WAIT_TRIG;
                    end
                end
                ST_PRE: begin
                    if (trigger) begin
                        trig_early_d = 1'b1;
                    end
                    if (pre_last) begin
                        state_d = ST_WAIT_TRIG;
                    end
                end
                ST_WAIT_TRIG: begin
                    if (trigger) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    // Unbounded captures never finish on stop; only abort ends them.
                    if (stop && do_limit_q) begin
                        state_d = ST_DONE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            limit_q      <= '0;
            do_limit_q   <= 1'b0;
            trig_early_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            limit_q      <= limit_d;
            do_limit_q   <= do_limit_d;
            trig_early_q <= trig_early_d;
        end
    end

    assign run        = (state_q == ST_RUN);
    assign sample_en  = st_is_busy(state_q);
    assign busy       = st_is_busy(state_q);
    assign done       = (state_q == ST_DONE);
    assign limit      = limit_q;
    assign do_limit   = do_limit_q;
    assign trig_early = trig_early_q;
    assign state      = state_q;

endmodule
